cronometro_ctrl: RTL and testbench



---
 rtl/cronometro_ctrl.sv | 125 ++++++++++++
 tb/tb_cronometro_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cronometro_ctrl.sv
// Stopwatch run/pause/lap/clear sequencer: turns two raw button levels into press
// events and paces a downstream counter through a DIV-cycle prescaler.
module cronometro_ctrl #(
    parameter int DIV      = 4,
    parameter int PRE_BITS = 8
) (
    input  logic       NEclk,
    input  logic       Nreset,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic       cnt_enable,
    output logic       cnt_nclear,
    output logic       hold,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(DIV - 1);

    state_t              state_reg, state_next;
    logic [PRE_BITS-1:0] pre_reg, pre_next;
    logic                en_reg, en_next;
    logic                nclear_reg, nclear_next;
    logic                hold_reg, hold_next;
    logic                ss_q, lr_q;
    logic                press_s, press_l;

    always_ff @(negedge NEclk or negedge Nreset) begin
        if (!Nreset) begin
            state_reg  <= IDLE;
            pre_reg    <= '0;
            en_reg     <= 1'b0;
            nclear_reg <= 1'b0;
            hold_reg   <= 1'b0;
            ss_q       <= 1'b0;
            lr_q       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pre_reg    <= pre_next;
            en_reg     <= en_next;
            nclear_reg <= nclear_next;
            hold_reg   <= hold_next;
            ss_q       <= start_stop;
            lr_q       <= lap_reset;
        end
    end

    always_comb begin
        press_s     = start_stop & ~ss_q;
        press_l     = lap_reset & ~lr_q;
        state_next  = state_reg;
        nclear_next = 1'b1;
        pre_next    = pre_reg;
        en_next     = 1'b0;

        // press_s is tested first everywhere so it wins over a simultaneous press_l
        case (state_reg)
            IDLE: begin
                if (press_s) begin
                    state_next = RUN;
                end else if (press_l) begin
                    nclear_next = 1'b0;
                end
            end
            RUN: begin
                if (press_s) begin
                    state_next = PAUSE;
                end else if (press_l) begin
                    state_next = LAP;
                end
            end
            LAP: begin
                if (press_s) begin
                    state_next = PAUSE;
                end else if (press_l) begin
                    state_next = RUN;
                end
            end
            PAUSE: begin
                if (press_s) begin
                    state_next = RUN;
                end else if (press_l) begin
                    state_next  = IDLE;
                    nclear_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Prescaler follows the state held before this edge; a pause request
        // freezes it in place (even at DIV-1) so resume keeps the partial period.
        case (state_reg)
            RUN, LAP: begin
                if (state_next == PAUSE) begin
                    pre_next = pre_reg;
                end else if (pre_reg == PRE_LAST) begin
                    pre_next = '0;
                    en_next  = 1'b1;
                end else begin
                    pre_next = pre_reg + 1'b1;
                end
            end
            PAUSE:   pre_next = pre_reg;
            default: pre_next = '0;
        endcase

        if (!nclear_next) begin
            pre_next = '0;
        end

        hold_next = (state_next == LAP);
    end

    assign cnt_enable = en_reg;
    assign cnt_nclear = nclear_reg;
    assign hold       = hold_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl (DIV=3): expected per-edge outputs are queued
// as each step is driven, then popped and checked just after the falling edge.
module tb_cronometro_ctrl;

    localparam int DIV = 3;

    logic       NEclk = 1'b1;
    logic       Nreset = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap_reset = 1'b0;
    logic       cnt_enable;
    logic       cnt_nclear;
    logic       hold;
    logic [1:0] state;

    int compared = 0;
    int mismatched = 0;
    int count = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       en;
        logic       ncl;
        logic       hld;
        int         cnt;
    } exp_t;

    exp_t sb[$];

    cronometro_ctrl #(.DIV(DIV), .PRE_BITS(8)) dut (
        .NEclk     (NEclk),
        .Nreset    (Nreset),
        .start_stop(start_stop),
        .lap_reset (lap_reset),
        .cnt_enable(cnt_enable),
        .cnt_nclear(cnt_nclear),
        .hold      (hold),
        .state     (state)
    );

    always #5 NEclk = ~NEclk;

    // Behavioural stand-in for the downstream contadorN counter.
    always @(negedge NEclk or negedge cnt_nclear) begin
        if (!cnt_nclear) count <= 0;
        else if (cnt_enable) count <= count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic ss, input logic lr,
                        input logic [1:0] st, input logic en, input logic ncl,
                        input logic hld, input int cnt);
        exp_t e;
        exp_t got;
        start_stop = ss;
        lap_reset  = lr;
        e.tag = tag; e.st = st; e.en = en; e.ncl = ncl; e.hld = hld; e.cnt = cnt;
        sb.push_back(e);
        @(negedge NEclk);
        #1;
        got = sb.pop_front();
        chk({got.tag, ".state"}, {30'd0, state}, {30'd0, got.st});
        chk({got.tag, ".en"},    {31'd0, cnt_enable}, {31'd0, got.en});
        chk({got.tag, ".nclr"},  {31'd0, cnt_nclear}, {31'd0, got.ncl});
        chk({got.tag, ".hold"},  {31'd0, hold}, {31'd0, got.hld});
        chk({got.tag, ".count"}, count, got.cnt);
        $display("step %-10s ss=%b lr=%b state=%b en=%b nclr=%b hold=%b count=%0d",
                 got.tag, ss, lr, state, cnt_enable, cnt_nclear, hold, count);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".state"}, {30'd0, state}, 32'd0);
        chk({tag, ".en"},    {31'd0, cnt_enable}, 32'd0);
        chk({tag, ".nclr"},  {31'd0, cnt_nclear}, 32'd0);
        chk({tag, ".hold"},  {31'd0, hold}, 32'd0);
        $display("reset %-10s state=%b en=%b nclr=%b hold=%b", tag, state, cnt_enable, cnt_nclear, hold);
    endtask

    initial begin
        #2;
        chk_reset("por");
        chk("por.count", count, 32'd0);
        #5 Nreset = 1'b1;                     // released between falling edges
        step("rel",     0, 0, 2'b00, 0, 1, 0, 0);
        step("idle",    0, 0, 2'b00, 0, 1, 0, 0);

        // start held 5 cycles: one press, pulses at edges 3, 6, 9
        step("start",   1, 0, 2'b01, 0, 1, 0, 0);
        step("run1",    1, 0, 2'b01, 0, 1, 0, 0);
        step("run2",    1, 0, 2'b01, 0, 1, 0, 0);
        step("run3",    1, 0, 2'b01, 1, 1, 0, 0);
        step("run4",    1, 0, 2'b01, 0, 1, 0, 1);
        step("run5",    0, 0, 2'b01, 0, 1, 0, 1);
        step("run6",    0, 0, 2'b01, 1, 1, 0, 1);
        step("run7",    0, 0, 2'b01, 0, 1, 0, 2);
        step("run8",    0, 0, 2'b01, 0, 1, 0, 2);
        step("run9",    0, 0, 2'b01, 1, 1, 0, 2);
        step("run10",   0, 0, 2'b01, 0, 1, 0, 3);

        // pause at pre=1, ten quiet cycles, resume: pulse 2 edges later
        step("pause",   1, 0, 2'b10, 0, 1, 0, 3);
        for (int i = 0; i < 10; i++) begin
            step("paused", (i == 0), 0, 2'b10, 0, 1, 0, 3);
        end
        step("resume",  1, 0, 2'b01, 0, 1, 0, 3);
        step("res1",    0, 0, 2'b01, 0, 1, 0, 3);
        step("res2",    0, 0, 2'b01, 1, 1, 0, 3);
        step("res3",    0, 0, 2'b01, 0, 1, 0, 4);

        // lap in and out without breaking the cadence
        step("lap",     0, 1, 2'b11, 0, 1, 1, 4);
        step("lap1",    0, 0, 2'b11, 1, 1, 1, 4);
        step("lap2",    0, 0, 2'b11, 0, 1, 1, 5);
        step("lap3",    0, 0, 2'b11, 0, 1, 1, 5);
        step("lap4",    0, 0, 2'b11, 1, 1, 1, 5);
        step("unlap",   0, 1, 2'b01, 0, 1, 0, 6);
        step("unlap1",  0, 0, 2'b01, 0, 1, 0, 6);
        step("unlap2",  0, 0, 2'b01, 1, 1, 0, 6);
        step("unlap3",  0, 0, 2'b01, 0, 1, 0, 7);
        step("unlap4",  0, 0, 2'b01, 0, 1, 0, 7);

        // pause exactly at pre==DIV-1: no pulse, then pulse on first edge after resume
        step("pauseW",  1, 0, 2'b10, 0, 1, 0, 7);
        step("pausedW", 0, 0, 2'b10, 0, 1, 0, 7);
        step("resumeW", 1, 0, 2'b01, 0, 1, 0, 7);
        step("resW1",   0, 0, 2'b01, 1, 1, 0, 7);
        step("resW2",   0, 0, 2'b01, 0, 1, 0, 8);

        // pause then clear: one-cycle clear, counter back to 0
        step("pause2",  1, 0, 2'b10, 0, 1, 0, 8);
        step("paused2", 0, 0, 2'b10, 0, 1, 0, 8);
        step("clear",   0, 1, 2'b00, 0, 0, 0, 0);
        step("clear1",  0, 0, 2'b00, 0, 1, 0, 0);

        // restart: first pulse DIV edges after start
        step("start2",  1, 0, 2'b01, 0, 1, 0, 0);
        step("st2_1",   0, 0, 2'b01, 0, 1, 0, 0);
        step("st2_2",   0, 0, 2'b01, 0, 1, 0, 0);
        step("st2_3",   0, 0, 2'b01, 1, 1, 0, 0);
        step("st2_4",   0, 0, 2'b01, 0, 1, 0, 1);

        // both buttons on the same edge: start/stop wins, no clear, no lap
        step("both",    1, 1, 2'b10, 0, 1, 0, 1);
        step("both1",   0, 0, 2'b10, 0, 1, 0, 1);
        step("resume3", 1, 0, 2'b01, 0, 1, 0, 1);
        step("res3_1",  0, 0, 2'b01, 0, 1, 0, 1);
        step("res3_2",  0, 0, 2'b01, 1, 1, 0, 1);

        // asynchronous reset with a pulse in flight, no clock edge in between
        #2 Nreset = 1'b0;
        #1;
        chk_reset("async");
        chk("async.count", count, 32'd0);

        // button already high at release counts as a press on the first edge
        start_stop = 1'b1;
        #3 Nreset = 1'b1;
        step("hotrel",  1, 0, 2'b01, 0, 1, 0, 0);
        step("hotrel1", 1, 0, 2'b01, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
